ahb_apb_bridge_ctrl: RTL and testbench
======================================

AHB_APB_BRIDGE_CTRL -- requirements
Module: ahb_apb_bridge_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of ACCESS cycles with pready low before abort (range 2..255).
REQ-003 clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 AHB inputs: haddr in 32; hwrite in 1; htrans in 2; hsize in 3; hburst in 3; hreadyin in 1; hwdata in 32.
REQ-006 AHB outputs: hreadyout out 1 (transfer done); hresp out 2 (00 OKAY, 01 ERROR); hrdata out 32 (read data).
REQ-007 APB outputs: psel out 3 (one-hot slave select); penable out 1; pwrite out 1; paddr out 32; pwdata out 32.
REQ-008 APB inputs: prdata in 32; pready in 1.

Function
REQ-009 Valid transfer: hreadyin=1, htrans in {10 NONSEQ, 11 SEQ}, and state IDLE; htrans 00/01 SHALL be ignored.
REQ-010 Each burst beat SHALL be a separate APB transfer; hburst and hsize SHALL not affect sequencing.
REQ-011 Decode: 8000_0000-83FF_FFFF -> psel 001; 8400_0000-87FF_FFFF -> 010; 8800_0000-8BFF_FFFF -> 100; any other address SHALL be an error.
REQ-012 States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2; all outputs SHALL be registered or decoded from registered state only.
REQ-013 IDLE: hreadyout=1, psel=000, penable=0. A valid decoded transfer SHALL latch haddr, hwrite and select. Next state: write -> WWAIT, read -> SETUP, undecoded -> ERR1.
REQ-014 WWAIT: hreadyout=0. At exit, hwdata SHALL be captured into pwdata. Next state is SETUP unconditionally.
REQ-015 SETUP: psel=latched select, penable=0, paddr/pwrite latched, hreadyout=0. Next state is ACCESS unconditionally.
REQ-016 ACCESS: psel held, penable=1, hreadyout=0, and paddr/pwrite/pwdata stable. pready=1 at the edge SHALL capture prdata into hrdata (reads only) and go to IDLE.
REQ-017 Wait counter: cleared on entry to ACCESS, incremented each ACCESS cycle with pready=0. pready=0 with counter = TIMEOUT-1 SHALL go to ERR1 and deassert psel/penable.
REQ-018 ERR1: hreadyout=0, hresp=01. ERR2: hreadyout=1, hresp=01. ERR1->ERR2->IDLE. A transfer presented during ERR2 SHALL be ignored.
REQ-019 hresp SHALL be 00 in every state other than ERR1/ERR2.
REQ-020 Latency without wait states: read SHALL have hreadyout low 2 cycles; write SHALL have hreadyout low 3 cycles.
REQ-021 hrdata SHALL hold its last captured value until the next completed read; writes and errors SHALL not modify it.
REQ-022 A transfer accepted in IDLE on the cycle hreadyout=1 completes the prior transfer SHALL be accepted with no lost beat (back-to-back pipelining).

Reset
REQ-023 rst=1 SHALL force at the next edge: state IDLE, hreadyout=1, hresp=00, hrdata=0, psel=000, penable=0, pwrite=0, paddr=0, pwdata=0, counter=0.
REQ-024 Reset asserted mid-transfer (any state) SHALL abort it. No APB strobe SHALL remain asserted in the cycle after the reset edge.
REQ-025 rst SHALL take priority over all other inputs.

Verification
REQ-026 Write haddr 8000_0001, hwdata A300_1111, pready=1 -> WWAIT, SETUP (psel 001, penable 0, pwdata A300_1111), ACCESS (penable 1), IDLE; hreadyout low exactly 3 cycles.
REQ-027 Read haddr 8400_00A2, prdata 0000_00A5, pready=1 -> psel 010, pwrite 0; hrdata=0000_00A5 with hreadyout=1 on the 3rd cycle after the address phase.
REQ-028 4-beat SEQ write burst from 8800_00C0 with pready held 0 for 3 ACCESS cycles per beat -> four APB transfers with psel 100 and paddr C0/C4/C8/CC, each ACCESS 4 cycles long, hresp 00 throughout.
REQ-029 Read of 9000_0000 -> no psel; ERR1 (hreadyout 0, hresp 01) then ERR2 (hreadyout 1, hresp 01), then IDLE.
REQ-030 Read of 8000_0010 with pready stuck 0, TIMEOUT=16 -> ACCESS 16 cycles, then psel/penable drop, two-cycle ERROR, hrdata unchanged.
REQ-031 rst=1 during ACCESS of a write -> next cycle psel=000, penable=0, hreadyout=1, pwdata=0; next valid transfer completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge_ctrl_if.sv
// Bus bundle between an AHB master, the AHB-to-APB bridge controller and its APB slaves.
// The bridge uses the slave modport; the environment driving AHB and answering APB uses master.
interface ahb_apb_bridge_ctrl_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hreadyin;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport slave (
        input  haddr, hwrite, htrans, hsize, hburst, hreadyin, hwdata, prdata, pready,
        output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
    );

    modport master (
        output haddr, hwrite, htrans, hsize, hburst, hreadyin, hwdata, prdata, pready,
        input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: one APB transfer per AHB beat, three decoded slaves,
// ACCESS wait-state timeout, and a two-cycle AHB ERROR response for bad addresses or timeouts.
module ahb_apb_bridge_ctrl #(
    parameter int TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst,
    ahb_apb_bridge_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        hreadyout_q, hreadyout_d;
    logic [1:0]  hresp_q, hresp_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        xfer_valid;
    logic [2:0]  addr_sel;
    logic        unused_bus_bits;

    // Burst type, size and the SEQ/NONSEQ distinction never change sequencing.
    assign unused_bus_bits = ^{bus.hsize, bus.hburst, bus.htrans[0]};

    assign xfer_valid = bus.hreadyin && bus.htrans[1] && (state_q == IDLE);

    // Each slave owns a 64 MB window starting at 0x8000_0000.
    always_comb begin
        addr_sel = 3'b000;
        case (bus.haddr[31:26])
            6'b100000: addr_sel = 3'b001;
            6'b100001: addr_sel = 3'b010;
            6'b100010: addr_sel = 3'b100;
            default:   addr_sel = 3'b000;
        endcase
    end

    // Next-state logic; every output is precomputed here so it comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hrdata_d    = hrdata_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (xfer_valid) begin
                    paddr_d     = bus.haddr;
                    pwrite_d    = bus.hwrite;
                    sel_d       = addr_sel;
                    hreadyout_d = 1'b0;
                    if (addr_sel == 3'b000) begin
                        state_d = ERR1;
                        hresp_d = HRESP_ERROR;
                    end else if (bus.hwrite) begin
                        state_d = WWAIT;
                    end else begin
                        state_d = SETUP;
                        psel_d  = addr_sel;
                    end
                end
            end
            WWAIT: begin
                pwdata_d = bus.hwdata;
                psel_d   = sel_q;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = 8'd0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    if (!pwrite_q) begin
                        hrdata_d = bus.prdata;
                    end
                    psel_d      = 3'b000;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d    = 3'b000;
                    penable_d = 1'b0;
                    hresp_d   = HRESP_ERROR;
                    state_d   = ERR1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ERR1: begin
                hreadyout_d = 1'b1;
                state_d     = ERR2;
            end
            ERR2: begin
                hresp_d = HRESP_OKAY;
                state_d = IDLE;
            end
            default: begin
                psel_d      = 3'b000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 3'b000;
            psel_q      <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            hrdata_q    <= 32'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;

    // An enable strobe without a select, or more than one select, is never legal APB.
    a_penable_has_psel : assert property (@(posedge clk) disable iff (rst)
        penable_q |-> (psel_q != 3'b000));
    a_psel_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(psel_q));

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Randomized self-checking bench for ahb_apb_bridge_ctrl against a transaction-level model
// of decode, latency, timeout and read-data behaviour.
module tb_ahb_apb_bridge_ctrl;

    localparam int TIMEOUT = 16;
    localparam int BOUND   = 400;

    logic clk = 1'b0;
    logic rst;

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] modelRdata;

    ahb_apb_bridge_ctrl_if bus();

    ahb_apb_bridge_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address map expressed as plain range comparisons.
    function automatic logic [2:0] modelSelect(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
        if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
        if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
        return 3'b000;
    endfunction

    task automatic driveIdle();
        bus.htrans   = 2'b00;
        bus.hreadyin = 1'b1;
        bus.haddr    = $urandom;
        bus.hwrite   = 1'($urandom);
        bus.hsize    = 3'($urandom);
        bus.hburst   = 3'($urandom);
        bus.pready   = 1'b0;
        bus.prdata   = $urandom;
    endtask

    task automatic checkReset();
        checkOutput("rstHready", 32'(bus.hreadyout), 32'd1);
        checkOutput("rstHresp", 32'(bus.hresp), 32'd0);
        checkOutput("rstHrdata", bus.hrdata, 32'd0);
        checkOutput("rstPsel", 32'(bus.psel), 32'd0);
        checkOutput("rstPenable", 32'(bus.penable), 32'd0);
        checkOutput("rstPwrite", 32'(bus.pwrite), 32'd0);
        checkOutput("rstPaddr", bus.paddr, 32'd0);
        checkOutput("rstPwdata", bus.pwdata, 32'd0);
    endtask

    // One AHB beat from address phase to completion, acting as the APB slave with 'waits' stalls.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata, input logic [1:0] trans);
        logic [2:0] expSel;
        bit         expErr;
        int         expLow, expAcc, lowCnt, accCnt;

        expSel = modelSelect(addr);
        if (expSel == 3'b000) begin
            expErr = 1'b1;
            expLow = 1;
            expAcc = 0;
        end else if (waits >= TIMEOUT) begin
            expErr = 1'b1;
            expLow = (wr ? 1 : 0) + 1 + TIMEOUT + 1;
            expAcc = TIMEOUT;
        end else begin
            expErr = 1'b0;
            expLow = (wr ? 1 : 0) + 1 + waits + 1;
            expAcc = waits + 1;
        end

        checkOutput("startReady", 32'(bus.hreadyout), 32'd1);
        bus.haddr    = addr;
        bus.hwrite   = wr;
        bus.htrans   = trans;
        bus.hreadyin = 1'b1;
        bus.hsize    = 3'($urandom);
        bus.hburst   = 3'($urandom);
        bus.hwdata   = $urandom;
        tick();
        bus.htrans = 2'b00;
        bus.haddr  = $urandom;
        bus.hwrite = 1'($urandom);
        bus.hwdata = wdata;

        lowCnt = 0;
        accCnt = 0;
        while (bus.hreadyout == 1'b0 && lowCnt < BOUND) begin
            lowCnt++;
            checkOutput("hrespLow", 32'(bus.hresp), (expErr && lowCnt == expLow) ? 32'd1 : 32'd0);
            if (bus.penable) begin
                accCnt++;
                checkOutput("accPsel", 32'(bus.psel), 32'(expSel));
                checkOutput("accPaddr", bus.paddr, addr);
                checkOutput("accPwrite", 32'(bus.pwrite), 32'(wr));
                if (wr) checkOutput("accPwdata", bus.pwdata, wdata);
                bus.pready = (accCnt > waits);
                bus.prdata = bus.pready ? rdata : $urandom;
            end else begin
                if (bus.psel != 3'b000) begin
                    checkOutput("setupPsel", 32'(bus.psel), 32'(expSel));
                    checkOutput("setupPaddr", bus.paddr, addr);
                    if (wr) checkOutput("setupPwdata", bus.pwdata, wdata);
                end
                bus.pready = 1'($urandom);
                bus.prdata = $urandom;
            end
            tick();
        end
        bus.pready = 1'b0;

        if (!expErr && !wr) modelRdata = rdata;
        checkOutput("lowCycles", 32'(lowCnt), 32'(expLow));
        checkOutput("accessCycles", 32'(accCnt), 32'(expAcc));
        checkOutput("doneHresp", 32'(bus.hresp), expErr ? 32'd1 : 32'd0);
        checkOutput("donePsel", 32'(bus.psel), 32'd0);
        checkOutput("donePenable", 32'(bus.penable), 32'd0);
        checkOutput("doneHrdata", bus.hrdata, modelRdata);

        if (expErr) begin
            // A valid-looking transfer during the second error cycle must be dropped.
            bus.haddr  = 32'h8000_0000 | ($urandom & 32'h03FF_FFFC);
            bus.hwrite = 1'($urandom);
            bus.htrans = 2'b10;
            tick();
            driveIdle();
            checkOutput("err2Ready", 32'(bus.hreadyout), 32'd1);
            checkOutput("err2Hresp", 32'(bus.hresp), 32'd0);
            checkOutput("err2Psel", 32'(bus.psel), 32'd0);
            checkOutput("err2Hrdata", bus.hrdata, modelRdata);
        end
    endtask

    // Cycles carrying IDLE/BUSY or hreadyin=0 must not start anything.
    task automatic ignoredCycle();
        bus.haddr  = 32'h8400_0000 | ($urandom & 32'h03FF_FFFC);
        bus.hwrite = 1'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            bus.htrans   = 2'($urandom_range(0, 1));
            bus.hreadyin = 1'b1;
        end else begin
            bus.htrans   = 2'($urandom_range(2, 3));
            bus.hreadyin = 1'b0;
        end
        tick();
        driveIdle();
        checkOutput("ignReady", 32'(bus.hreadyout), 32'd1);
        checkOutput("ignPsel", 32'(bus.psel), 32'd0);
        checkOutput("ignHresp", 32'(bus.hresp), 32'd0);
    endtask

    task automatic midResetTest();
        int n;
        bus.haddr    = 32'h8800_0000 | ($urandom & 32'h03FF_FFFC);
        bus.hwrite   = 1'b1;
        bus.htrans   = 2'b10;
        bus.hreadyin = 1'b1;
        tick();
        bus.htrans = 2'b00;
        bus.hwdata = $urandom | 32'h1;
        bus.pready = 1'b0;
        n = 0;
        while (bus.penable == 1'b0 && n < 10) begin
            n++;
            tick();
        end
        checkOutput("reachAccess", 32'(bus.penable), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        driveIdle();
        modelRdata = 32'd0;
        checkReset();
    endtask

    initial begin
        int          kind;
        int          w;
        logic [31:0] a;
        logic [31:0] base;

        rst = 1'b1;
        driveIdle();
        bus.hwdata = 32'd0;
        modelRdata = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        checkReset();
        tick();

        applyStimulus(32'h8000_0001, 1'b1, 32'hA300_1111, 0, 32'd0, 2'b10);
        applyStimulus(32'h8400_00A2, 1'b0, 32'd0, 0, 32'h0000_00A5, 2'b10);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(32'h8800_00C0 + 32'(4 * b), 1'b1, $urandom, 3, 32'd0, (b == 0) ? 2'b10 : 2'b11);
        end
        applyStimulus(32'h9000_0000, 1'b0, 32'd0, 0, $urandom, 2'b10);
        applyStimulus(32'h8000_0010, 1'b0, 32'd0, 1000, $urandom, 2'b10);
        applyStimulus(32'h83FF_FFFC, 1'b0, 32'd0, TIMEOUT - 1, 32'h1234_5678, 2'b10);
        applyStimulus(32'h8BFF_FFFC, 1'b1, 32'hCAFE_F00D, TIMEOUT, 32'd0, 2'b10);
        applyStimulus(32'h8C00_0000, 1'b1, $urandom, 0, 32'd0, 2'b10);
        applyStimulus(32'h7FFF_FFFC, 1'b0, 32'd0, 0, $urandom, 2'b10);
        midResetTest();
        applyStimulus(32'h8800_0004, 1'b0, 32'd0, 1, 32'h5A5A_0001, 2'b10);

        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: base = 32'h8000_0000;
                3, 4:    base = 32'h8400_0000;
                5, 6:    base = 32'h8800_0000;
                default: base = 32'h0000_0000;
            endcase
            if (base == 32'h0) a = $urandom;
            else               a = base | ($urandom & 32'h03FF_FFFF);
            if ($urandom_range(0, 7) == 0) w = TIMEOUT + $urandom_range(0, 3);
            else                           w = $urandom_range(0, 5);
            applyStimulus(a, 1'($urandom), $urandom, w, $urandom, 2'($urandom_range(2, 3)));
            if ($urandom_range(0, 5) == 0) ignoredCycle();
            if ($urandom_range(0, 19) == 0) midResetTest();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
